uno_seq: RTL and testbench
==========================

# uno_seq

Micro-sequencer that drives the select lines of one `uno` PE and collects its result. It accepts an operation command (mode, length) over a valid/ready handshake and issues one select triple (XSEL/YSEL/ZSEL) per cycle for the scheduled length. It then waits out the MAC pipeline latency, captures the PE output and presents it on a valid/ready result port. It sits between the PE-array controller and each `uno` instance.

## Interface
- MAC_BW, default `MAC_BW` (from param_def.sv): PE operand width; result width is 2*MAC_BW.
- LEN_W, default 8: width of the command length field.
- MAC_LAT, default 1: cycles from an issue cycle to its result on mac_out.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_mode  in  2  0 DOT, 1 NORM, 2 SUM, 3 reserved (executes as DOT).
- cmd_len  in  LEN_W  number of issue cycles.
- XSEL  out  2  X select: 00 ifm, 01 ifm_var, 10 ifm_scale, 11 sum_x.
- YSEL  out  2  Y select: 00 weight, 01 sum_y, 10 ifm_coeff_0, 11 constant 1.
- ZSEL  out  2  Z select: 00 ifm_coeff_1, 01 ifm_offset, 10 sum_z, 11 sum_o.
- issue_valid  out  1  selects valid this cycle; upstream presents operands.
- issue_first / issue_last  out  1  first / last issue cycle of the command.
- busy  out  1  state != IDLE.
- mac_out  in  2*MAC_BW  `uno` out.
- res_valid  out  1  result held on res_data.
- res_ready  in  1  result consumer accepts.
- res_data  out  2*MAC_BW  captured result.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
- IDLE: cmd_ready = 1. On cmd_valid && cmd_ready, latch mode and effective length L, then go to ISSUE.
- Effective length: L = cmd_len, except cmd_len = 0 gives L = 1 for DOT/SUM, and NORM uses L = max(cmd_len, 2).
- ISSUE: issue_valid = 1 for exactly L cycles; an issue counter runs 0..L-1. At count L-1, go to DRAIN.
- Schedules for (XSEL, YSEL, ZSEL):
  - DOT: count 0 uses (00, 00, 01), bias init from ifm_offset. Later counts use (00, 00, 10), accumulating.
  - NORM: count 0 uses (01, 10, 00). Middle counts use (00, 00, 10). The last count uses (10, 01, 01), applying scale and offset.
  - SUM: every count uses (11, 11, 10). Counts 0 through L-1.
- DRAIN: a latency counter runs MAC_LAT cycles. On the final DRAIN cycle, load res_data <= mac_out, then go to HOLD.
- HOLD: res_valid = 1 and res_data is stable. On res_ready, clear res_valid and go to IDLE.
- cmd_ready is 0 in ISSUE, DRAIN and HOLD. Only one command is in flight at a time.
- Selects and issue flags are registered. Outside ISSUE they read 00 with all flags 0.
- Reset: a synchronous rst_n = 0 at any state, including mid-ISSUE or HOLD, forces IDLE on the next edge.
  - The in-flight command and any held result are discarded with no res_valid pulse.
  - Reset values: XSEL/YSEL/ZSEL = 0, issue_valid = 0, issue_first = 0, issue_last = 0, busy = 0, res_valid = 0, res_data = 0.
  - cmd_ready is forced to 0 while rst_n = 0.

## Timing
- Command accepted at edge E. The first issue cycle is E+1 (issue_first = 1). The last issue cycle is E+L (issue_last = 1).
- When L = 1, issue_first and issue_last are both 1 in the same cycle.
- mac_out is sampled at the end of cycle E+L+MAC_LAT. res_valid rises in cycle E+L+MAC_LAT+1.
- Command-to-result latency is L + MAC_LAT + 1 cycles.
- res_valid && res_ready at edge F: res_valid = 0 and cmd_ready = 1 in cycle F+1.
- A new command can be accepted at the edge ending cycle F+1. Minimum command spacing is L + MAC_LAT + 2 cycles.
- cmd_valid held during busy: the command is not consumed. It is accepted on the first IDLE edge.
- res_ready held at 1: HOLD lasts exactly 1 cycle.

## Test plan
- Reset, then DOT with cmd_len = 4, MAC_LAT = 1:
  - issue_valid high for cycles 1-4, with ZSEL = 01 then 10, 10, 10.
  - Model mac_out = 0x1234 in cycle 5; res_data = 0x1234 with res_valid in cycle 6.
- NORM with cmd_len = 3:
  - Select triples are (01,10,00), (00,00,10), (10,01,01).
  - NORM with cmd_len = 1 issues exactly 2 cycles: first and last triples only.
- SUM with cmd_len = 0:
  - Exactly one issue cycle with (11,11,10) and issue_first = issue_last = 1.
  - Mode 3 with cmd_len = 2 produces the DOT schedule.
- Backpressure:
  - Hold res_ready = 0 for 10 cycles: res_data stays stable, cmd_ready stays 0, and a pending cmd_valid is not accepted.
  - Assert res_ready: cmd_ready = 1 one cycle later.
- Reset mid-operation:
  - Drop rst_n during issue cycle 2 of a DOT with cmd_len = 8: all outputs return to reset values on the next edge and no res_valid occurs.
  - Drop rst_n while in HOLD: res_valid clears on the next edge.
- Sweep MAC_LAT = 1, 3 with back-to-back commands: capture timing matches L + MAC_LAT + 1 in every case.

Source files
------------

// File: rtl/uno_seq.sv
// uno_seq: micro-sequencer for a single uno PE.
// Accepts one (mode, length) command at a time, streams the select triple
// for each issue cycle, waits out the MAC pipeline, then holds the captured
// result on a valid/ready port until the consumer takes it.
`ifndef MAC_BW
`define MAC_BW 16
`endif

module uno_seq #(
  parameter int MAC_BW  = `MAC_BW,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic [1:0]          XSEL,
  output logic [1:0]          YSEL,
  output logic [1:0]          ZSEL,
  output logic                issue_valid,
  output logic                issue_first,
  output logic                issue_last,
  output logic                busy,
  input  logic [2*MAC_BW-1:0] mac_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2*MAC_BW-1:0] res_data
);

  localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Mode encodings; reserved mode 3 is folded onto DOT at accept time.
  localparam logic [1:0] MODE_DOT  = 2'd0;
  localparam logic [1:0] MODE_NORM = 2'd1;
  localparam logic [1:0] MODE_SUM  = 2'd2;

  state_t              state_reg;
  logic [1:0]          mode_reg;
  logic [LEN_W-1:0]    cnt_reg;
  logic [LEN_W-1:0]    last_reg;   // index of the final issue cycle (L-1)
  logic [LAT_W-1:0]    lat_reg;
  logic [1:0]          xsel_reg, ysel_reg, zsel_reg;
  logic                issue_valid_reg, issue_first_reg, issue_last_reg;
  logic                res_valid_reg;
  logic [2*MAC_BW-1:0] res_data_reg;

  logic [1:0]          acc_mode;
  logic [LEN_W-1:0]    acc_last;
  logic [LEN_W-1:0]    cnt_next;

  // Issue-cycle outputs for a given count: {valid, first, last, X, Y, Z}.
  function automatic logic [8:0] sched(input logic [1:0] mode,
                                       input logic [LEN_W-1:0] cnt,
                                       input logic [LEN_W-1:0] last);
    logic [5:0] trip;
    logic       is_first;
    logic       is_last;
    is_first = (cnt == '0);
    is_last  = (cnt == last);
    case (mode)
      MODE_NORM: begin
        if (is_first)     trip = 6'b01_10_00;  // variance x coeff_0 seeds the sum
        else if (is_last) trip = 6'b10_01_01;  // scale x sum_y + offset
        else              trip = 6'b00_00_10;  // accumulate
      end
      MODE_SUM:  trip = 6'b11_11_10;
      default: begin
        if (is_first)     trip = 6'b00_00_01;  // bias init from ifm_offset
        else              trip = 6'b00_00_10;
      end
    endcase
    return {1'b1, is_first, is_last, trip};
  endfunction

  // Decode the incoming command: fold reserved mode, clamp length to the
  // minimum each schedule needs (NORM needs distinct first and last cycles).
  always_comb begin
    acc_mode = (cmd_mode == 2'd3) ? MODE_DOT : cmd_mode;
    acc_last = '0;
    if (acc_mode == MODE_NORM) begin
      if (cmd_len < LEN_W'(2)) acc_last = LEN_W'(1);
      else                     acc_last = cmd_len - LEN_W'(1);
    end else begin
      if (cmd_len == '0)       acc_last = '0;
      else                     acc_last = cmd_len - LEN_W'(1);
    end
  end

  assign cnt_next = cnt_reg + LEN_W'(1);

  // Main sequencer FSM with registered selects, flags and result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      mode_reg        <= MODE_DOT;
      cnt_reg         <= '0;
      last_reg        <= '0;
      lat_reg         <= '0;
      xsel_reg        <= 2'b00;
      ysel_reg        <= 2'b00;
      zsel_reg        <= 2'b00;
      issue_valid_reg <= 1'b0;
      issue_first_reg <= 1'b0;
      issue_last_reg  <= 1'b0;
      res_valid_reg   <= 1'b0;
      res_data_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            mode_reg  <= acc_mode;
            last_reg  <= acc_last;
            cnt_reg   <= '0;
            {issue_valid_reg, issue_first_reg, issue_last_reg,
             xsel_reg, ysel_reg, zsel_reg} <= sched(acc_mode, '0, acc_last);
            state_reg <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cnt_reg == last_reg) begin
            {issue_valid_reg, issue_first_reg, issue_last_reg,
             xsel_reg, ysel_reg, zsel_reg} <= '0;
            lat_reg   <= '0;
            state_reg <= S_DRAIN;
          end else begin
            cnt_reg <= cnt_next;
            {issue_valid_reg, issue_first_reg, issue_last_reg,
             xsel_reg, ysel_reg, zsel_reg} <= sched(mode_reg, cnt_next, last_reg);
          end
        end
        S_DRAIN: begin
          if (lat_reg == LAT_W'(MAC_LAT - 1)) begin
            res_data_reg  <= mac_out;
            res_valid_reg <= 1'b1;
            state_reg     <= S_HOLD;
          end else begin
            lat_reg <= lat_reg + LAT_W'(1);
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = rst_n && (state_reg == S_IDLE);
  assign busy        = (state_reg != S_IDLE);
  assign XSEL        = xsel_reg;
  assign YSEL        = ysel_reg;
  assign ZSEL        = zsel_reg;
  assign issue_valid = issue_valid_reg;
  assign issue_first = issue_first_reg;
  assign issue_last  = issue_last_reg;
  assign res_valid   = res_valid_reg;
  assign res_data    = res_data_reg;

endmodule

// File: tb/tb_uno_seq.sv
// tb_uno_seq: self-checking bench for uno_seq. Two instances (MAC_LAT 1 and 3)
// share clock, reset, command fields and mac_out; each has its own
// cmd_valid / res_ready. Outputs are sampled on the falling edge.
module tb_uno_seq;
  localparam int MAC_BW = 16;
  localparam int LEN_W  = 8;
  localparam int RW     = 2 * MAC_BW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       cmd_mode;
  logic [LEN_W-1:0] cmd_len;
  logic [RW-1:0]    mac_out;
  logic             cmd_valid [2];
  logic             res_ready [2];

  logic             cmd_ready_w   [2];
  logic [1:0]       xsel_w        [2];
  logic [1:0]       ysel_w        [2];
  logic [1:0]       zsel_w        [2];
  logic             issue_valid_w [2];
  logic             issue_first_w [2];
  logic             issue_last_w  [2];
  logic             busy_w        [2];
  logic             res_valid_w   [2];
  logic [RW-1:0]    res_data_w    [2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q [$];   // {valid, first, last, X, Y, Z} per issue cycle

  uno_seq #(.MAC_BW(MAC_BW), .LEN_W(LEN_W), .MAC_LAT(1)) dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready_w[0]),
    .cmd_mode(cmd_mode), .cmd_len(cmd_len),
    .XSEL(xsel_w[0]), .YSEL(ysel_w[0]), .ZSEL(zsel_w[0]),
    .issue_valid(issue_valid_w[0]), .issue_first(issue_first_w[0]),
    .issue_last(issue_last_w[0]), .busy(busy_w[0]),
    .mac_out(mac_out), .res_valid(res_valid_w[0]),
    .res_ready(res_ready[0]), .res_data(res_data_w[0])
  );

  uno_seq #(.MAC_BW(MAC_BW), .LEN_W(LEN_W), .MAC_LAT(3)) dut_lat3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready_w[1]),
    .cmd_mode(cmd_mode), .cmd_len(cmd_len),
    .XSEL(xsel_w[1]), .YSEL(ysel_w[1]), .ZSEL(zsel_w[1]),
    .issue_valid(issue_valid_w[1]), .issue_first(issue_first_w[1]),
    .issue_last(issue_last_w[1]), .busy(busy_w[1]),
    .mac_out(mac_out), .res_valid(res_valid_w[1]),
    .res_ready(res_ready[1]), .res_data(res_data_w[1])
  );

  // Snapshot of control outputs: {cmd_ready, busy, issue[8:0], res_valid}.
  function automatic logic [11:0] obs(input int w);
    return {cmd_ready_w[w], busy_w[w], issue_valid_w[w], issue_first_w[w],
            issue_last_w[w], xsel_w[w], ysel_w[w], zsel_w[w], res_valid_w[w]};
  endfunction

  // Reference schedule from the mode/length rules.
  task automatic build_sched(input int mode, input int len);
    int L;
    logic [5:0] t;
    exp_q.delete();
    if (mode == 1) L = (len < 2) ? 2 : len;
    else           L = (len == 0) ? 1 : len;
    for (int k = 0; k < L; k++) begin
      case (mode)
        1:       t = (k == 0) ? 6'b01_10_00 : ((k == L-1) ? 6'b10_01_01 : 6'b00_00_10);
        2:       t = 6'b11_11_10;
        default: t = (k == 0) ? 6'b00_00_01 : 6'b00_00_10;
      endcase
      exp_q.push_back({1'b1, (k == 0), (k == L-1), t});
    end
  endtask

  // Runs one command on instance w starting at a falling edge; ends at the
  // falling edge of the cycle after the result handshake (or after reset).
  task automatic run_cmd(input int w, input int mode, input int len, input int hold,
                         input bit pend, input int rst_issue, input bit rst_hold,
                         input logic [RW-1:0] val);
    int L;
    int lat;
    bit abort;
    logic [11:0] o;
    lat = (w == 0) ? 1 : 3;
    abort = 1'b0;
    build_sched(mode, len);
    L = exp_q.size();
    cmd_mode = 2'(mode);
    cmd_len  = LEN_W'(len);
    cmd_valid[w] = 1'b1;
    o = obs(w);
    n_checks++;
    if (o !== 12'b1000_0000_0000) begin
      n_fail++; $display("FAIL accept_idle dut%0d: got %b expected %b", w, o, 12'b1000_0000_0000);
    end
    @(negedge clk);
    cmd_valid[w] = 1'b0;
    for (int k = 0; k < L && !abort; k++) begin
      o = obs(w);
      n_checks++;
      if (o !== {2'b01, exp_q[k], 1'b0}) begin
        n_fail++; $display("FAIL issue[%0d] dut%0d mode%0d len%0d: got %b expected %b",
                           k, w, mode, len, o, {2'b01, exp_q[k], 1'b0});
      end
      mac_out = ~val;
      if (k == rst_issue) abort = 1'b1;
      else @(negedge clk);
    end
    for (int d = 0; d < lat && !abort; d++) begin
      o = obs(w);
      n_checks++;
      if (o !== 12'b0100_0000_0000) begin
        n_fail++; $display("FAIL drain[%0d] dut%0d: got %b expected %b", d, w, o, 12'b0100_0000_0000);
      end
      mac_out = (d == lat-1) ? val : ~val;
      @(negedge clk);
    end
    for (int h = 0; h <= hold && !abort; h++) begin
      o = obs(w);
      n_checks++;
      if (o !== 12'b0100_0000_0001 || res_data_w[w] !== val) begin
        n_fail++; $display("FAIL hold[%0d] dut%0d: got %b/%h expected %b/%h",
                           h, w, o, res_data_w[w], 12'b0100_0000_0001, val);
      end
      mac_out = ~val;
      if (pend) cmd_valid[w] = 1'b1;
      if (rst_hold && h == 0) abort = 1'b1;
      else begin
        res_ready[w] = (h == hold);
        @(negedge clk);
      end
    end
    if (abort) begin
      rst_n = 1'b0;
      @(negedge clk);
      o = obs(w);
      n_checks++;
      if (o !== 12'b0 || res_data_w[w] !== '0) begin
        n_fail++; $display("FAIL reset_abort dut%0d: got %b/%h expected %b/%h", w, o, res_data_w[w], 12'b0, 32'h0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        o = obs(w);
        n_checks++;
        if (o !== 12'b1000_0000_0000) begin
          n_fail++; $display("FAIL post_reset[%0d] dut%0d: got %b expected %b", i, w, o, 12'b1000_0000_0000);
        end
      end
      $display("cmd dut%0d mode %0d len %0d L %0d aborted by reset", w, mode, len, L);
    end else begin
      res_ready[w] = 1'b0;
      o = obs(w);
      n_checks++;
      if (o !== 12'b1000_0000_0000) begin
        n_fail++; $display("FAIL release dut%0d: got %b expected %b", w, o, 12'b1000_0000_0000);
      end
      $display("cmd dut%0d mode %0d len %0d L %0d lat %0d hold %0d res %h", w, mode, len, L, lat, hold, val);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      n_checks++;
      if (obs(w) !== 12'b0 || res_data_w[w] !== '0) begin
        n_fail++; $display("FAIL reset_state dut%0d: got %b/%h expected %b/%h", w, obs(w), res_data_w[w], 12'b0, 32'h0);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      n_checks++;
      if (obs(w) !== 12'b1000_0000_0000) begin
        n_fail++; $display("FAIL reset_release dut%0d: got %b expected %b", w, obs(w), 12'b1000_0000_0000);
      end
    end
  endtask

  task automatic test_dot();
    run_cmd(0, 0, 4, 0, 1'b0, -1, 1'b0, 32'h0000_1234);
  endtask

  task automatic test_norm();
    run_cmd(0, 1, 3, 0, 1'b0, -1, 1'b0, 32'hA5A5_0001);
    run_cmd(0, 1, 1, 0, 1'b0, -1, 1'b0, 32'hA5A5_0002);
    run_cmd(0, 1, 0, 1, 1'b0, -1, 1'b0, 32'hA5A5_0003);
  endtask

  task automatic test_sum();
    run_cmd(0, 2, 0, 0, 1'b0, -1, 1'b0, 32'h5555_0001);
    run_cmd(0, 3, 2, 0, 1'b0, -1, 1'b0, 32'h5555_0002);
  endtask

  task automatic test_backpressure();
    run_cmd(0, 0, 4, 10, 1'b1, -1, 1'b0, 32'hBEEF_0001);
    run_cmd(0, 0, 4, 0, 1'b0, -1, 1'b0, 32'hBEEF_0002);
  endtask

  task automatic test_reset_mid();
    run_cmd(0, 0, 8, 0, 1'b0, 1, 1'b0, 32'hDEAD_0001);
    run_cmd(0, 0, 2, 0, 1'b0, -1, 1'b1, 32'hDEAD_0002);
    run_cmd(1, 2, 3, 0, 1'b0, -1, 1'b1, 32'hDEAD_0003);
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 4; i++)
        run_cmd(w, $urandom_range(0, 3), $urandom_range(0, 6), 0, 1'b0, -1, 1'b0, $urandom);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      run_cmd($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 9),
              $urandom_range(0, 3), 1'b0, -1, 1'b0, $urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_mode = 2'd0;
    cmd_len = '0;
    mac_out = '0;
    cmd_valid[0] = 1'b0; cmd_valid[1] = 1'b0;
    res_ready[0] = 1'b0; res_ready[1] = 1'b0;
    test_reset();
    test_dot();
    test_norm();
    test_sum();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
